// File: rtl/led_pkg.sv
// Shared types and helpers for the LED step sequencer.
// The step record is declared inside the top because its duration width is a top parameter.
package led_pkg;

    localparam int LED_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    function automatic int calc_tick_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

endpackage

// File: rtl/led_sequence_ctrl_tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks, restartable via clr.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_sequence_ctrl.sv
// Plays a loaded table of (pattern, duration) steps on the LED bank, once or looped.
// Durations are counted in prescaler ticks; a zero duration still lasts one tick.
module led_sequence_ctrl
    import led_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int NUM_STEPS = 8,
    parameter int DUR_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
    input  logic [LED_W-1:0]             cfg_pattern,
    input  logic [DUR_W-1:0]             cfg_duration,
    input  logic                         cfg_last,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
    output logic [LED_W-1:0]             leds,
    output logic                         busy,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         done
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, TICK_HZ);
    localparam int IDX_W    = $clog2(NUM_STEPS);

    typedef struct packed {
        logic [LED_W-1:0] pattern;
        logic [DUR_W-1:0] duration;
    } step_t;

    state_e             state_q, state_d;
    step_t              tbl_q [NUM_STEPS];
    logic [IDX_W-1:0]   idx_q, idx_d, end_q, end_d, nxt;
    logic [DUR_W-1:0]   rem_q, rem_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               done_q, done_d;
    logic               tick, clr, wr_en;

    function automatic logic [DUR_W-1:0] step_ticks(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign wr_en = cfg_valid && (state_q == IDLE);
    // stop beats start in IDLE, so a suppressed start must not disturb the prescaler
    assign clr   = (state_q == IDLE) && start && !stop;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = end_q;
        rem_d   = rem_q;
        leds_d  = leds_q;
        done_d  = 1'b0;
        nxt     = (idx_q == end_q) ? '0 : idx_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (wr_en && cfg_last) end_d = cfg_addr;
                if (clr) begin
                    state_d = PLAY;
                    idx_d   = '0;
                    rem_d   = step_ticks(tbl_q[0].duration);
                    leds_d  = tbl_q[0].pattern;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    leds_d  = '0;
                end else if (tick) begin
                    if (rem_q != DUR_W'(1)) begin
                        rem_d = rem_q - 1'b1;
                    end else if (idx_q != end_q || loop_en) begin
                        idx_d  = nxt;
                        rem_d  = step_ticks(tbl_q[nxt].duration);
                        leds_d = tbl_q[nxt].pattern;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        leds_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            end_q   <= '0;
            rem_q   <= '0;
            leds_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            rem_q   <= rem_d;
            leds_q  <= leds_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
        end else if (wr_en) begin
            tbl_q[cfg_addr] <= '{pattern: cfg_pattern, duration: cfg_duration};
        end
    end

    assign leds      = leds_q;
    assign busy      = (state_q == PLAY);
    assign cfg_ready = (state_q == IDLE);
    assign step_idx  = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl with TICK_DIV=10; per-cycle expectations are queued then drained.
module tb_led_sequence_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_pattern = '0;
    logic [15:0] cfg_duration = '0;
    logic        cfg_last = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [7:0]  leds;
    logic        busy;
    logic [2:0]  step_idx;
    logic        done;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    // expected {leds, busy, done, cfg_ready}, one entry per clock cycle
    logic [10:0] sb [$];
    string       tag = "";

    led_sequence_ctrl #(
        .CLK_FREQ  (1000),
        .TICK_HZ   (100),
        .NUM_STEPS (8),
        .DUR_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_pattern  (cfg_pattern),
        .cfg_duration (cfg_duration),
        .cfg_last     (cfg_last),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .leds         (leds),
        .busy         (busy),
        .step_idx     (step_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic b, input logic d, input int n);
        for (int i = 0; i < n; i++) sb.push_back({l, b, d, ~b});
    endtask

    task automatic drain();
        logic [10:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, {21'd0, leds, busy, done, cfg_ready}, {21'd0, e});
            tick();
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] p, input logic [15:0] d, input logic l);
        cfg_valid = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_duration = d; cfg_last = l;
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_state", {21'd0, leds, busy, done, cfg_ready}, 32'h1);
        chk("reset_step_idx", {29'd0, step_idx}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single pass
        cfg_wr(3'd0, 8'h55, 16'd3, 1'b0);
        cfg_wr(3'd1, 8'hAA, 16'd2, 1'b1);
        tag = "single_pass";
        pulse_start();
        push(8'h55, 1, 0, 30); push(8'hAA, 1, 0, 20); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 2);
        drain();

        // looping, then drop loop_en during step1 of the second pass
        tag = "loop";
        loop_en = 1'b1;
        pulse_start();
        push(8'h55, 1, 0, 30); push(8'hAA, 1, 0, 20); push(8'h55, 1, 0, 30); push(8'hAA, 1, 0, 5);
        drain();
        loop_en = 1'b0;
        tag = "loop_exit";
        push(8'hAA, 1, 0, 15); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 2);
        drain();

        // blocked config write during play, then stop 5 cycles into step1
        tag = "stop_run";
        pulse_start();
        push(8'h55, 1, 0, 10);
        drain();
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_pattern = 8'hFF; cfg_duration = 16'd1; cfg_last = 1'b1;
        tag = "cfg_blocked";
        push(8'h55, 1, 0, 1);
        drain();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        tag = "stop_run";
        push(8'h55, 1, 0, 19); push(8'hAA, 1, 0, 5);
        drain();
        stop = 1'b1;
        push(8'hAA, 1, 0, 1);
        drain();
        stop = 1'b0;
        tag = "after_stop";
        push(8'h00, 0, 0, 3);
        drain();

        // replay shows the table was not altered by the blocked write
        tag = "replay";
        pulse_start();
        push(8'h55, 1, 0, 30); push(8'hAA, 1, 0, 20); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
        drain();

        // zero duration behaves as one tick
        cfg_wr(3'd0, 8'h0F, 16'd0, 1'b1);
        tag = "dur_zero";
        pulse_start();
        push(8'h0F, 1, 0, 10); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
        drain();

        // start and stop together in IDLE
        tag = "start_stop_idle";
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        push(8'h00, 0, 0, 3);
        drain();

        // start during play does not disturb timing
        tag = "restart_ignored";
        pulse_start();
        push(8'h0F, 1, 0, 5);
        drain();
        start = 1'b1;
        push(8'h0F, 1, 0, 1);
        drain();
        start = 1'b0;
        push(8'h0F, 1, 0, 4); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
        drain();

        // asynchronous reset mid-playback
        tag = "pre_reset";
        pulse_start();
        push(8'h0F, 1, 0, 3);
        drain();
        rst = 1'b1;
        #1;
        chk("async_reset", {21'd0, leds, busy, done, cfg_ready}, 32'h1);
        #1 rst = 1'b0;
        tick();

        // table cleared by reset: step0 is pattern 0, duration 0
        tag = "post_reset_table";
        pulse_start();
        push(8'h00, 1, 0, 10); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
